// File: rtl/eth_rt_tx_arbiter.sv
// Round-robin arbiter for the real-time Ethernet TX path (resp vs. fwd) with interpacket gap
// and start/transfer watchdogs. Define ETH_TX_ARB_STATS_EN to add grant/timeout counters.
//
// state     | meaning
// IDLE      | waiting for a pending request while EthernetIO is idle
// START     | send_request high, waiting for send_busy to rise
// BUSY      | transfer in progress, transfer watchdog running
// WAIT_IDLE | transfer timed out, waiting for send_busy to drop
// GAP       | interpacket gap before the next grant
module eth_rt_tx_arbiter #(
    parameter int IPG_CYCLES    = 12,
    parameter int START_TIMEOUT = 255,
    parameter int TX_TIMEOUT    = 12000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_errors,
    input  logic        req_resp,
    input  logic        req_fwd,
    input  logic        send_busy,
    output logic        send_request,
    output logic        is_forward,
    output logic [1:0]  gnt,
    output logic        tx_timeout_err,
    input  logic [15:0] reg_raddr,
    output logic [31:0] reg_rdata
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        BUSY      = 3'd2,
        WAIT_IDLE = 3'd3,
        GAP       = 3'd4
    } state_t;

    localparam logic [15:0] IPG_LAST   = 16'(IPG_CYCLES - 1);
    localparam logic [15:0] START_LAST = 16'(START_TIMEOUT - 1);
    localparam logic [15:0] TX_LAST    = 16'(TX_TIMEOUT - 1);

    state_t      state, stateNext;
    logic [15:0] cnt, cntNext, cntInc;
    logic        pendResp, pendFwd, pendRespNext, pendFwdNext;
    logic        last, lastNext;      // 1 = fwd was granted last
    logic [1:0]  gntNext;
    logic        sendReqNext, isFwdNext, errNext;
    logic        grantEn, grantFwd, timeoutEv;

    assign cntInc   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign grantFwd = pendFwd && (!pendResp || !last);

    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        gntNext     = gnt;
        sendReqNext = send_request;
        isFwdNext   = is_forward;
        lastNext    = last;
        grantEn     = 1'b0;
        timeoutEv   = 1'b0;
        case (state)
            IDLE: begin
                if ((pendResp || pendFwd) && !send_busy) begin
                    grantEn     = 1'b1;
                    gntNext     = grantFwd ? 2'b10 : 2'b01;
                    isFwdNext   = grantFwd;
                    lastNext    = grantFwd;
                    sendReqNext = 1'b1;
                    cntNext     = 16'd0;
                    stateNext   = START;
                end
            end
            START: begin
                if (send_busy) begin
                    sendReqNext = 1'b0;
                    cntNext     = 16'd0;
                    stateNext   = BUSY;
                end else if (cnt == START_LAST) begin
                    // aborted grant is dropped, not re-pended
                    sendReqNext = 1'b0;
                    timeoutEv   = 1'b1;
                    gntNext     = 2'b00;
                    cntNext     = 16'd0;
                    stateNext   = GAP;
                end else begin
                    cntNext = cntInc;
                end
            end
            BUSY: begin
                if (!send_busy) begin
                    gntNext   = 2'b00;
                    cntNext   = 16'd0;
                    stateNext = GAP;
                end else if (cnt == TX_LAST) begin
                    timeoutEv = 1'b1;
                    gntNext   = 2'b00;
                    stateNext = WAIT_IDLE;
                end else begin
                    cntNext = cntInc;
                end
            end
            WAIT_IDLE: begin
                if (!send_busy) begin
                    cntNext   = 16'd0;
                    stateNext = GAP;
                end
            end
            GAP: begin
                if (cnt == IPG_LAST) stateNext = IDLE;
                else                 cntNext   = cntInc;
            end
            default: stateNext = IDLE;
        endcase
        // a new pulse on the grant clock keeps the request pending
        pendRespNext = req_resp | (pendResp & ~(grantEn & ~grantFwd));
        pendFwdNext  = req_fwd  | (pendFwd  & ~(grantEn &  grantFwd));
        errNext      = timeoutEv | (tx_timeout_err & ~clear_errors);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= 16'd0;
            pendResp       <= 1'b0;
            pendFwd        <= 1'b0;
            last           <= 1'b0;
            gnt            <= 2'b00;
            send_request   <= 1'b0;
            is_forward     <= 1'b0;
            tx_timeout_err <= 1'b0;
        end else begin
            state          <= stateNext;
            cnt            <= cntNext;
            pendResp       <= pendRespNext;
            pendFwd        <= pendFwdNext;
            last           <= lastNext;
            gnt            <= gntNext;
            send_request   <= sendReqNext;
            is_forward     <= isFwdNext;
            tx_timeout_err <= errNext;
        end
    end

`ifdef ETH_TX_ARB_STATS_EN
    logic [7:0] numResp, numFwd, numTimeout;
    logic       unusedRaddr;

    // an increment on the clearing clock survives the clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            numResp    <= 8'd0;
            numFwd     <= 8'd0;
            numTimeout <= 8'd0;
        end else begin
            numResp    <= (clear_errors ? 8'd0 : numResp)    + {7'd0, grantEn & ~grantFwd};
            numFwd     <= (clear_errors ? 8'd0 : numFwd)     + {7'd0, grantEn &  grantFwd};
            numTimeout <= (clear_errors ? 8'd0 : numTimeout) + {7'd0, timeoutEv};
        end
    end

    always_comb begin
        reg_rdata = 32'd0;
        if (reg_raddr[7:4] == 4'hb) begin
            case (reg_raddr[1:0])
                2'd0:    reg_rdata = 32'h4152_4254;
                2'd1:    reg_rdata = {8'd0, numTimeout, numFwd, numResp};
                2'd2:    reg_rdata = {24'd0, state, pendFwd, pendResp, last, gnt};
                default: reg_rdata = 32'd0;
            endcase
        end
    end

    assign unusedRaddr = ^{reg_raddr[15:8], reg_raddr[3:2]};
`else
    logic unusedRaddr;

    assign reg_rdata   = 32'd0;
    assign unusedRaddr = ^reg_raddr;
`endif

endmodule
